// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end and its ALU:
// key codes, opcodes, FSM states and key classification.
package calc_pkg;

    localparam logic [3:0] KeyAdd    = 4'hA;
    localparam logic [3:0] KeySub    = 4'hB;
    localparam logic [3:0] KeyEquals = 4'hC;
    localparam logic [3:0] KeyClear  = 4'hD;

    localparam logic [2:0] OpNone = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;

    localparam logic [1:0] MaxDigits = 2'd2;

    typedef enum logic [2:0] {
        StEnterOp1,
        StEnterOp2,
        StExec,
        StShowResult,
        StError
    } state_e;

    typedef enum logic [2:0] {
        KcNone,
        KcDigit,
        KcOper,
        KcEquals,
        KcClear
    } key_e;

    // 4'hE/4'hF and idle cycles both classify as KcNone.
    function automatic key_e classify_key(input logic strobe, input logic [3:0] code);
        key_e k;
        k = KcNone;
        if (strobe) begin
            if (code <= 4'd9) begin
                k = KcDigit;
            end else if (code == KeyAdd || code == KeySub) begin
                k = KcOper;
            end else if (code == KeyEquals) begin
                k = KcEquals;
            end else if (code == KeyClear) begin
                k = KcClear;
            end
        end
        return k;
    endfunction

    function automatic logic [2:0] key_opcode(input logic [3:0] code);
        return (code == KeySub) ? OpSub : OpAdd;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Two-digit BCD entry register: shifts digits in from the right, saturates
// at two digits, and supports synchronous clear and parallel load.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic [1:0] load_count,
    input  logic       shift,
    input  logic [3:0] digit,
    output logic [7:0] value,
    output logic [1:0] count
);

    logic [7:0] value_q, value_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (load) begin
            value_d = load_value;
            count_d = load_count;
        end else if (shift && (count_q < MaxDigits)) begin
            value_d = {value_q[3:0], digit};
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/calc_input_fsm.sv
// Keypad input sequencer for a two-digit BCD calculator: collects operands
// and operator, fires the ALU for one cycle, and drives the display.
module calc_input_fsm
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_strobe,
    input  logic [3:0] key_code,
    output logic [8:0] op1,
    output logic [8:0] op2,
    output logic [2:0] opcode,
    output logic       alu_valid,
    input  logic [8:0] result_in,
    input  logic       o_flag_in,
    input  logic       sign_in,
    output logic [7:0] display,
    output logic       display_neg,
    output logic       err
);

    state_e     state_q, state_d;
    key_e       key;

    logic       op1_clr, op1_load, op1_shift;
    logic [7:0] op1_load_value;
    logic [1:0] op1_load_count;
    logic [7:0] op1_value;
    logic [1:0] op1_count;

    logic       op2_clr, op2_shift;
    logic [7:0] op2_value;
    logic [1:0] op2_count;

    logic [2:0] opcode_q, opcode_d;
    logic [7:0] res_q, res_d;
    logic       res_sign_q, res_sign_d;

    // The ALU also reports the sign in result_in[8]; sign_in is the one stored.
    logic       unused_result_sign;
    assign unused_result_sign = result_in[8];

    assign key = classify_key(key_strobe, key_code);
    wire clear_req = (key == KcClear) && (state_q != StExec);

    bcd_entry_reg u_op1 (
        .clk        (clk),
        .rst        (rst),
        .clr        (op1_clr),
        .load       (op1_load),
        .load_value (op1_load_value),
        .load_count (op1_load_count),
        .shift      (op1_shift),
        .digit      (key_code),
        .value      (op1_value),
        .count      (op1_count)
    );

    bcd_entry_reg u_op2 (
        .clk        (clk),
        .rst        (rst),
        .clr        (op2_clr),
        .load       (1'b0),
        .load_value (8'h00),
        .load_count (2'd0),
        .shift      (op2_shift),
        .digit      (key_code),
        .value      (op2_value),
        .count      (op2_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEnterOp1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEnterOp1: begin
                if (key == KcOper) state_d = StEnterOp2;
            end
            StEnterOp2: begin
                if (key == KcEquals && op2_count != 2'd0) state_d = StExec;
            end
            StExec: begin
                state_d = o_flag_in ? StError : StShowResult;
            end
            StShowResult: begin
                if (key == KcDigit) begin
                    state_d = StEnterOp1;
                end else if (key == KcOper && !res_sign_q) begin
                    state_d = StEnterOp2;
                end
            end
            StError: begin
                state_d = state_q;
            end
            default: state_d = StEnterOp1;
        endcase
        if (clear_req) state_d = StEnterOp1;
    end

    always_comb begin
        op1_clr        = 1'b0;
        op1_load       = 1'b0;
        op1_load_value = '0;
        op1_load_count = '0;
        op1_shift      = 1'b0;
        op2_clr        = 1'b0;
        op2_shift      = 1'b0;
        opcode_d       = opcode_q;
        res_d          = res_q;
        res_sign_d     = res_sign_q;
        if (clear_req) begin
            op1_clr    = 1'b1;
            op2_clr    = 1'b1;
            opcode_d   = OpNone;
            res_d      = '0;
            res_sign_d = 1'b0;
        end else begin
            unique case (state_q)
                StEnterOp1: begin
                    if (key == KcDigit) begin
                        op1_shift = (op1_count < MaxDigits);
                    end else if (key == KcOper) begin
                        opcode_d = key_opcode(key_code);
                        op2_clr  = 1'b1;
                    end
                end
                StEnterOp2: begin
                    if (key == KcDigit) begin
                        op2_shift = 1'b1;
                    end else if (key == KcOper && op2_count == 2'd0) begin
                        opcode_d = key_opcode(key_code);
                    end
                end
                StExec: begin
                    res_d      = result_in[7:0];
                    res_sign_d = sign_in;
                end
                StShowResult: begin
                    if (key == KcDigit) begin
                        op1_load       = 1'b1;
                        op1_load_value = {4'h0, key_code};
                        op1_load_count = 2'd1;
                        op2_clr        = 1'b1;
                        opcode_d       = OpNone;
                    end else if (key == KcOper && !res_sign_q) begin
                        // Chain: a non-negative result becomes the next first operand.
                        op1_load       = 1'b1;
                        op1_load_value = res_q;
                        op1_load_count = MaxDigits;
                        op2_clr        = 1'b1;
                        opcode_d       = key_opcode(key_code);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q   <= OpNone;
            res_q      <= '0;
            res_sign_q <= 1'b0;
        end else begin
            opcode_q   <= opcode_d;
            res_q      <= res_d;
            res_sign_q <= res_sign_d;
        end
    end

    always_comb begin
        alu_valid   = (state_q == StExec);
        err         = (state_q == StError);
        display_neg = (state_q == StShowResult) && res_sign_q;
        unique case (state_q)
            StEnterOp1:           display = op1_value;
            StEnterOp2:           display = op2_value;
            StExec, StShowResult: display = res_q;
            default:              display = 8'h00;
        endcase
    end

    assign op1    = {1'b0, op1_value};
    assign op2    = {1'b0, op2_value};
    assign opcode = opcode_q;

endmodule

// File: tb/tb_calc_input_fsm.sv
// Self-checking bench for calc_input_fsm: directed scenarios plus random
// key streams compared against a decimal-arithmetic calculator model.
module tb_calc_input_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_strobe = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [8:0] op1, op2, result_in;
    logic [2:0] opcode;
    logic       alu_valid, o_flag_in, sign_in;
    logic [7:0] display;
    logic       display_neg, err;
    logic [31:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int MOp1 = 0, MOp2 = 1, MExec = 2, MShow = 3, MErr = 4;
    int m_mode, m_a, m_b, m_ca, m_cb, m_op, m_res;
    bit m_neg;
    int alu_r, alu_mag;

    calc_input_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .op1         (op1),
        .op2         (op2),
        .opcode      (opcode),
        .alu_valid   (alu_valid),
        .result_in   (result_in),
        .o_flag_in   (o_flag_in),
        .sign_in     (sign_in),
        .display     (display),
        .display_neg (display_neg),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign obs = {op1, op2, opcode, alu_valid, display, display_neg, err};

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Decimal ALU fed from whatever operands the DUT presents.
    always_comb begin
        if (opcode == 3'b010) alu_r = bcd2int(op1[7:0]) - bcd2int(op2[7:0]);
        else                  alu_r = bcd2int(op1[7:0]) + bcd2int(op2[7:0]);
        alu_mag   = (alu_r < 0) ? -alu_r : alu_r;
        sign_in   = (alu_r < 0);
        o_flag_in = (alu_mag > 99);
        result_in = {alu_r < 0, int2bcd(alu_mag % 100)};
    end

    function automatic void m_reset();
        m_mode = MOp1; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 0; m_res = 0; m_neg = 0;
    endfunction

    // Calculator behaviour for one clock edge given the key seen in that cycle.
    function automatic void model_edge(input bit stb, input logic [3:0] k);
        int r, mag, d;
        d = int'(k);
        if (m_mode == MExec) begin
            r     = (m_op == 1) ? m_a + m_b : m_a - m_b;
            mag   = (r < 0) ? -r : r;
            m_neg = (r < 0);
            m_res = mag % 100;
            m_mode = (mag > 99) ? MErr : MShow;
        end else if (stb) begin
            if (k == 4'hD) begin
                m_reset();
            end else if (m_mode == MErr || k >= 4'hE) begin
                // ignored
            end else if (d <= 9) begin
                if (m_mode == MOp1 && m_ca < 2) begin
                    m_a = (m_a % 10) * 10 + d; m_ca++;
                end else if (m_mode == MOp2 && m_cb < 2) begin
                    m_b = (m_b % 10) * 10 + d; m_cb++;
                end else if (m_mode == MShow) begin
                    m_a = d; m_ca = 1; m_b = 0; m_cb = 0; m_op = 0; m_mode = MOp1;
                end
            end else if (k == 4'hA || k == 4'hB) begin
                if (m_mode == MOp1) begin
                    m_op = (k == 4'hA) ? 1 : 2; m_b = 0; m_cb = 0; m_mode = MOp2;
                end else if (m_mode == MOp2 && m_cb == 0) begin
                    m_op = (k == 4'hA) ? 1 : 2;
                end else if (m_mode == MShow && !m_neg) begin
                    m_a = m_res; m_ca = 2; m_op = (k == 4'hA) ? 1 : 2;
                    m_b = 0; m_cb = 0; m_mode = MOp2;
                end
            end else if (k == 4'hC) begin
                if (m_mode == MOp2 && m_cb >= 1) m_mode = MExec;
            end
        end
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [7:0] disp;
        logic [2:0] opc;
        opc = (m_op == 1) ? 3'b001 : (m_op == 2) ? 3'b010 : 3'b000;
        case (m_mode)
            MOp1:        disp = int2bcd(m_a);
            MOp2:        disp = int2bcd(m_b);
            MExec, MShow: disp = int2bcd(m_res);
            default:     disp = 8'h00;
        endcase
        return {1'b0, int2bcd(m_a), 1'b0, int2bcd(m_b), opc, (m_mode == MExec), disp,
                (m_mode == MShow) && m_neg, (m_mode == MErr)};
    endfunction

    // One clock cycle with an optional key; returns #1 after the edge.
    task automatic step(input bit stb, input logic [3:0] k);
        key_strobe = stb;
        key_code   = k;
        @(posedge clk);
        #1;
        key_strobe = 1'b0;
        model_edge(stb, k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        m_reset();
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", obs, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 4'h0);
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic_add();
        step(1, 4'hD); step(1, 4'd1); step(1, 4'd2); step(1, 4'hA); step(1, 4'd3); step(1, 4'd4);
        n_checks++;
        if ({op1, op2, opcode, alu_valid} !== {9'h012, 9'h034, 3'b001, 1'b0}) begin
            n_fail++; $display("FAIL add_operands got %h want %h",
                               {op1, op2, opcode, alu_valid}, {9'h012, 9'h034, 3'b001, 1'b0});
        end
        step(1, 4'hC);
        n_checks++;
        if ({op1, op2, opcode, alu_valid} !== {9'h012, 9'h034, 3'b001, 1'b1}) begin
            n_fail++; $display("FAIL add_exec got %h want %h",
                               {op1, op2, opcode, alu_valid}, {9'h012, 9'h034, 3'b001, 1'b1});
        end
        step(0, 4'h0);
        n_checks++;
        if ({alu_valid, display, display_neg, err} !== {1'b0, 8'h46, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL add_result got %h want %h",
                               {alu_valid, display, display_neg, err}, {1'b0, 8'h46, 1'b0, 1'b0});
        end
    endtask

    task automatic test_negative();
        step(1, 4'hD); step(1, 4'd5); step(1, 4'hB); step(1, 4'd8); step(1, 4'hC); step(0, 4'h0);
        n_checks++;
        if ({display, display_neg, err} !== {8'h03, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL neg_result got %h want %h",
                               {display, display_neg, err}, {8'h03, 1'b1, 1'b0});
        end
        step(1, 4'hA);
        step(0, 4'h0);
        n_checks++;
        if ({op1, opcode, alu_valid, display, display_neg} !== {9'h005, 3'b010, 1'b0, 8'h03, 1'b1})
        begin
            n_fail++; $display("FAIL neg_chain_ignored got %h want %h",
                               {op1, opcode, alu_valid, display, display_neg},
                               {9'h005, 3'b010, 1'b0, 8'h03, 1'b1});
        end
    endtask

    task automatic test_overflow();
        step(1, 4'hD); step(1, 4'd9); step(1, 4'd9); step(1, 4'hA);
        step(1, 4'd9); step(1, 4'd9); step(1, 4'hC); step(0, 4'h0);
        n_checks++;
        if ({err, display, display_neg} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL ovf_error got %h want %h",
                               {err, display, display_neg}, {1'b1, 8'h00, 1'b0});
        end
        step(1, 4'd7); step(1, 4'hC); step(1, 4'hA);
        n_checks++;
        if ({err, display, alu_valid} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL ovf_keys_ignored got %h want %h",
                               {err, display, alu_valid}, {1'b1, 8'h00, 1'b0});
        end
        step(1, 4'hD);
        n_checks++;
        if ({err, display, op1, opcode} !== {1'b0, 8'h00, 9'h000, 3'b000}) begin
            n_fail++; $display("FAIL ovf_clear got %h want %h",
                               {err, display, op1, opcode}, {1'b0, 8'h00, 9'h000, 3'b000});
        end
        step(1, 4'd1);
        n_checks++;
        if (display !== 8'h01) begin
            n_fail++; $display("FAIL ovf_reentry got %h want %h", display, 8'h01);
        end
    endtask

    task automatic test_entry_limit();
        step(1, 4'hD); step(1, 4'd1); step(1, 4'd2); step(1, 4'd3);
        n_checks++;
        if ({op1, display} !== {9'h012, 8'h12}) begin
            n_fail++; $display("FAIL limit_op1 got %h want %h", {op1, display}, {9'h012, 8'h12});
        end
        step(1, 4'hA); step(1, 4'hB);
        n_checks++;
        if ({opcode, op2} !== {3'b010, 9'h000}) begin
            n_fail++; $display("FAIL limit_op_replace got %h want %h", {opcode, op2}, {3'b010, 9'h000});
        end
        step(1, 4'hC); step(0, 4'h0);
        n_checks++;
        if ({alu_valid, display, err} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL limit_eq_ignored got %h want %h",
                               {alu_valid, display, err}, {1'b0, 8'h00, 1'b0});
        end
        step(1, 4'd4); step(1, 4'hA);
        n_checks++;
        if ({opcode, op2} !== {3'b010, 9'h004}) begin
            n_fail++; $display("FAIL limit_op_after_digit got %h want %h",
                               {opcode, op2}, {3'b010, 9'h004});
        end
    endtask

    task automatic test_chain();
        step(1, 4'hD); step(1, 4'd2); step(1, 4'hA); step(1, 4'd3); step(1, 4'hC); step(0, 4'h0);
        n_checks++;
        if (display !== 8'h05) begin
            n_fail++; $display("FAIL chain_first got %h want %h", display, 8'h05);
        end
        step(1, 4'hA);
        n_checks++;
        if ({op1, opcode, display} !== {9'h005, 3'b001, 8'h00}) begin
            n_fail++; $display("FAIL chain_load got %h want %h",
                               {op1, opcode, display}, {9'h005, 3'b001, 8'h00});
        end
        step(1, 4'd4); step(1, 4'hC); step(0, 4'h0);
        n_checks++;
        if ({op1, op2, display, display_neg} !== {9'h005, 9'h004, 8'h09, 1'b0}) begin
            n_fail++; $display("FAIL chain_second got %h want %h",
                               {op1, op2, display, display_neg}, {9'h005, 9'h004, 8'h09, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        step(1, 4'hD); step(1, 4'd6); step(1, 4'hB); step(1, 4'd1); step(1, 4'hC);
        step(1, 4'hD);
        n_checks++;
        if ({display, display_neg, op1} !== {8'h05, 1'b0, 9'h006}) begin
            n_fail++; $display("FAIL b2b_clear_dropped got %h want %h",
                               {display, display_neg, op1}, {8'h05, 1'b0, 9'h006});
        end
        step(1, 4'd2);
        n_checks++;
        if ({op1, op2, opcode, display} !== {9'h002, 9'h000, 3'b000, 8'h02}) begin
            n_fail++; $display("FAIL b2b_new_entry got %h want %h",
                               {op1, op2, opcode, display}, {9'h002, 9'h000, 3'b000, 8'h02});
        end
        step(1, 4'hA); step(1, 4'd3); step(1, 4'hC); step(1, 4'd9); step(1, 4'hC);
        n_checks++;
        if ({display, alu_valid, err} !== {8'h05, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_digit_dropped got %h want %h",
                               {display, alu_valid, err}, {8'h05, 1'b0, 1'b0});
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL b2b_model got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_noop();
        step(1, 4'hD); step(1, 4'd4); step(1, 4'hE); step(1, 4'hF); step(1, 4'hA);
        step(1, 4'hF); step(1, 4'hE);
        n_checks++;
        if ({op1, op2, opcode, display} !== {9'h004, 9'h000, 3'b001, 8'h00}) begin
            n_fail++; $display("FAIL noop_entry got %h want %h",
                               {op1, op2, opcode, display}, {9'h004, 9'h000, 3'b001, 8'h00});
        end
    endtask

    task automatic test_async_reset();
        step(1, 4'hD); step(1, 4'd7); step(1, 4'hA); step(1, 4'd8); step(1, 4'hC);
        n_checks++;
        if (alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_in_exec got %b want %b", alu_valid, 1'b1);
        end
        #3 rst = 1'b1;
        #1;
        m_reset();
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++; $display("FAIL arst_immediate got %h want %h", obs, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 4'h0);
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++; $display("FAIL arst_no_capture got %h want %h", obs, 32'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            int r;
            bit s;
            logic [3:0] k;
            r = int'($urandom_range(0, 99));
            s = 1'b1;
            if (r < 25) begin
                s = 1'b0; k = 4'h0;
            end else if (r < 65) begin
                k = 4'($urandom_range(0, 9));
            end else if (r < 77) begin
                k = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
            end else if (r < 89) begin
                k = 4'hC;
            end else if (r < 94) begin
                k = 4'hD;
            end else begin
                k = ($urandom_range(0, 1) == 0) ? 4'hE : 4'hF;
            end
            step(s, k);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d key=%h got %h want %h", i, k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_basic_add();
        test_negative();
        test_overflow();
        test_entry_limit();
        test_chain();
        test_back_to_back();
        test_noop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_input_fsm.md
CALC_INPUT_FSM -- requirements
Module: calc_input_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below and no other ports.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 key_strobe  in  1  one-cycle pulse marking key_code as valid.
REQ-005 key_code  in  4  0-9 digit, 4'hA add, 4'hB subtract, 4'hC equals, 4'hD clear, 4'hE/4'hF no-op.
REQ-006 op1  out  9  ALU operand 1, packed {sign, tens BCD, ones BCD}.
REQ-007 op2  out  9  ALU operand 2, same packing.
REQ-008 opcode  out  3  3'b001 add, 3'b010 subtract, 3'b000 none.
REQ-009 alu_valid  out  1  high only while the block is in EXEC.
REQ-010 result_in  in  9  ALU result, packed {sign, tens, ones}.
REQ-011 o_flag_in  in  1  ALU overflow flag.
REQ-012 sign_in  in  1  ALU sign output.
REQ-013 display  out  8  two BCD digits currently shown.
REQ-014 display_neg  out  1  minus indicator.
REQ-015 err  out  1  high while in ERROR.

Function
REQ-016 The FSM SHALL have the states ENTER_OP1, ENTER_OP2, EXEC, SHOW_RESULT and ERROR.
REQ-017 Digit handling: in ENTER_OP1/ENTER_OP2, a digit strobe SHALL shift the active operand as tens<=ones, ones<=digit; sign bit stays 0.
REQ-018 Entry limit: digit count SHALL saturate at 2, and a third or later digit SHALL be ignored with the operand unchanged.
REQ-019 Operator in ENTER_OP1: an add or subtract strobe SHALL latch opcode, clear op2 and its count, and go to ENTER_OP2; op1 is 0 if no digits were entered.
REQ-020 Operator in ENTER_OP2 before any op2 digit: the strobe SHALL replace opcode only.
REQ-021 Operator in ENTER_OP2 after an op2 digit: the strobe SHALL be ignored.
REQ-022 Equals in ENTER_OP2 with op2 count >=1: the block SHALL go to EXEC on the next edge.
REQ-023 Equals ignored: equals in ENTER_OP1, or in ENTER_OP2 with count 0, SHALL be ignored.
REQ-024 EXEC timing: EXEC SHALL last exactly one cycle, with op1/op2/opcode stable and alu_valid=1.
REQ-025 EXEC capture: at the end of EXEC, the block SHALL capture result_in[7:0] and sign_in into the result register.
REQ-026 EXEC exit: the block SHALL then go to ERROR if o_flag_in=1, otherwise to SHOW_RESULT.
REQ-027 Latency: an equals strobe in cycle N SHALL give EXEC in N+1 and the updated display in N+2.
REQ-028 Strobes during EXEC SHALL be dropped.
REQ-029 Chaining from SHOW_RESULT: an add or subtract strobe with stored sign=0 SHALL load op1={0, result digits}, latch opcode, clear op2, and go to ENTER_OP2.
REQ-030 The same operator strobe with stored sign=1 SHALL be ignored.
REQ-031 New entry from SHOW_RESULT: a digit strobe SHALL clear all operands, load op1 ones=digit with count 1, and go to ENTER_OP1; equals SHALL be ignored.
REQ-032 Clear SHALL, in any state except EXEC, zero op1, op2, opcode, counts and the result register, and go to ENTER_OP1 on the next edge.
REQ-033 ERROR SHALL ignore every key except clear.
REQ-034 Display SHALL show op1[7:0] in ENTER_OP1, op2[7:0] in ENTER_OP2, the result digits in EXEC/SHOW_RESULT, and 8'h00 in ERROR.
REQ-035 display_neg SHALL be the stored sign in SHOW_RESULT and 0 otherwise.
REQ-036 No-op codes 4'hE and 4'hF SHALL change no state in any state.
REQ-037 All outputs SHALL be registered or decoded from state only, with no combinational path from key inputs to outputs.

Reset
REQ-038 On rst high, the block SHALL asynchronously enter ENTER_OP1 with op1=op2=9'h000, opcode=3'b000, alu_valid=0, display=8'h00, display_neg=0, err=0, counts=0 and result register=0.
REQ-039 An assertion of rst during EXEC SHALL discard the pending ALU capture.

Structure
REQ-040 A shared package calc_pkg SHALL hold the key-code constants, the opcode constants (shared with the ALU) and the state enum typedef.
REQ-041 One sub-module bcd_entry_reg SHALL implement the 2-digit shift register with saturating count, plus load and clear; the block SHALL instantiate it once per operand.

Verification
REQ-042 Keys 1,2,add,3,4,equals with ALU model -> op1=9'h012, op2=9'h034, opcode=001, alu_valid for exactly 1 cycle, display=8'h46 two cycles after equals.
REQ-043 Keys 5,sub,8,equals, model returns result 9'h103 with sign_in=1 -> display=8'h03, display_neg=1; a following add strobe is ignored and the state stays SHOW_RESULT.
REQ-044 Keys 9,9,add,9,9,equals, model o_flag_in=1 -> err=1, display=8'h00; digit and equals ignored; clear -> ENTER_OP1, err=0.
REQ-045 Keys 1,2,3 -> op1=9'h012 (third digit ignored); add then sub before any digit -> opcode=010.
REQ-046 rst asserted mid-cycle during EXEC -> all outputs at reset values immediately (asynchronous), and no result is captured.
REQ-047 Chain: 2,add,3,equals (result 9'h005), then add,4,equals -> op1=9'h005, display=8'h09.
